// File: rtl/if_id_stage.sv
// if_id_stage: program counter, instruction fetch and IF/ID register with flush/stall and saturating event counters
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      branch_target_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      instr_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [31:0]      r_pc_q;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] w_stall_nxt;
  logic [CNT_W-1:0] w_flush_nxt;
  always_comb begin
    w_stall_nxt = &r_stall_cnt ? r_stall_cnt : r_stall_cnt + CNT_ONE;
    w_flush_nxt = &r_flush_cnt ? r_flush_cnt : r_flush_cnt + CNT_ONE;
  end
  // flush outranks stall; a stall cycle that is also a flush is counted only as a flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc_q      <= RESET_PC;
      r_pc        <= '0;
      r_instr     <= NOP_INSTR;
      r_valid     <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (flush_i) begin
      r_pc_q      <= {branch_target_i[31:2], 2'b00};
      r_pc        <= '0;
      r_instr     <= NOP_INSTR;
      r_valid     <= 1'b0;
      r_flush_cnt <= w_flush_nxt;
    end else if (stall_i) begin
      r_stall_cnt <= w_stall_nxt;
    end else begin
      r_pc_q      <= r_pc_q + 32'd4;
      r_pc        <= r_pc_q;
      r_instr     <= imem_instr_i;
      r_valid     <= 1'b1;
    end
  end
  assign imem_addr_o = r_pc_q;
  assign pc_o        = r_pc;
  assign instr_o     = r_instr;
  assign valid_o     = r_valid;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: randomized scoreboard bench for two parameterisations of if_id_stage
module tb_if_id_stage;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] po;
    logic [31:0] ins;
    logic        v;
    int          sc;
    int          fc;
  } st_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] addr0, instr0, pc0, ins0;
  logic        v0;
  logic [15:0] sc0, fc0;
  logic [31:0] addr1, instr1, pc1, ins1;
  logic        v1;
  logic [3:0]  sc1, fc1;
  int total = 0;
  int bad = 0;
  st_t m0, m1;
  st_t q0[$];
  st_t q1[$];
  always #5 clk = ~clk;
  assign instr0 = addr0 ^ 32'hA5A5_0000;
  assign instr1 = addr1 ^ 32'hA5A5_0000;
  if_id_stage dut0 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .branch_target_i(tgt),
    .imem_addr_o(addr0), .imem_instr_i(instr0), .pc_o(pc0), .instr_o(ins0), .valid_o(v0),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0)
  );
  if_id_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .branch_target_i(tgt),
    .imem_addr_o(addr1), .imem_instr_i(instr1), .pc_o(pc1), .instr_o(ins1), .valid_o(v1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );
  function automatic st_t init(input logic [31:0] rpc);
    st_t s;
    s.pc = rpc; s.po = '0; s.ins = 32'h0000_0013; s.v = 1'b0; s.sc = 0; s.fc = 0;
    return s;
  endfunction
  // reference: what the IF/ID state must be after one edge with the given controls
  function automatic st_t step(input st_t s, input bit st, input bit fl, input logic [31:0] t, input int mx);
    st_t n = s;
    if (fl) begin
      n.pc = t & 32'hFFFF_FFFC; n.po = '0; n.ins = 32'h0000_0013; n.v = 1'b0;
      n.fc = (s.fc < mx) ? s.fc + 1 : s.fc;
    end else if (st) begin
      n.sc = (s.sc < mx) ? s.sc + 1 : s.sc;
    end else begin
      n.pc = s.pc + 32'd4; n.po = s.pc; n.ins = s.pc ^ 32'hA5A5_0000; n.v = 1'b1;
    end
    return n;
  endfunction
  function automatic st_t get0();
    st_t a;
    a.pc = addr0; a.po = pc0; a.ins = ins0; a.v = v0; a.sc = int'(sc0); a.fc = int'(fc0);
    return a;
  endfunction
  function automatic st_t get1();
    st_t a;
    a.pc = addr1; a.po = pc1; a.ins = ins1; a.v = v1; a.sc = int'(sc1); a.fc = int'(fc1);
    return a;
  endfunction
  task automatic chk(input string nm, input st_t a, input st_t e);
    total++;
    if (a.pc !== e.pc || a.po !== e.po || a.ins !== e.ins || a.v !== e.v || a.sc != e.sc || a.fc != e.fc) begin
      bad++;
      $display("FAIL %s t=%0t: got addr=%h pc=%h instr=%h v=%b sc=%0d fc=%0d, expected addr=%h pc=%h instr=%h v=%b sc=%0d fc=%0d",
               nm, $time, a.pc, a.po, a.ins, a.v, a.sc, a.fc, e.pc, e.po, e.ins, e.v, e.sc, e.fc);
    end
  endtask
  task automatic cyc(input bit st, input bit fl, input logic [31:0] t);
    @(negedge clk);
    #1;
    stall = st; flush = fl; tgt = t;
    m0 = step(m0, st, fl, t, 65535);
    m1 = step(m1, st, fl, t, 15);
    q0.push_back(m0);
    q1.push_back(m1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    m0 = init(32'h0000_0000);
    m1 = init(32'hFFFF_FFF8);
    #1;
    chk("reset0", get0(), m0);
    chk("reset1", get1(), m1);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) chk("dut0", get0(), q0.pop_front());
      if (q1.size() > 0) chk("dut1", get1(), q1.pop_front());
    end
  end
  initial begin
    do_reset();
    repeat (2) cyc(0, 0, '0);
    repeat (3) cyc(1, 0, '0);
    cyc(0, 0, '0);
    cyc(0, 1, 32'h0000_0103);
    repeat (2) cyc(0, 0, '0);
    cyc(1, 1, 32'h0000_0040);
    repeat (2) cyc(0, 0, '0);
    repeat (20) cyc(1, 0, '0);
    repeat (3) cyc(0, 0, '0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cyc($urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0, $urandom);
    end
    cyc(0, 0, '0);
    @(posedge clk);
    #3;
    if (q0.size() != 0 || q1.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d/%0d entries left, expected 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
